// File: rtl/mixer_i2s_transmitter.sv
// mixer_i2s_transmitter: takes stereo sample pairs from the mixer over valid/ready
// and serializes them as Philips I2S (one-bit delay after the lrclk edge, MSB first).
// bclk and lrclk are derived from clk by a programmable divider.
// Optional build macro: MIXER_I2S_TX_REPEAT_ON_UNDERRUN_EN
//   defined   -> an underrun frame repeats the last transmitted pair
//   undefined -> an underrun frame transmits zeros
module mixer_i2s_transmitter #(
  parameter int AUDIO_WIDTH_P = 24,
  parameter int SLOT_WIDTH_P  = 32,
  parameter int DIV_WIDTH_P   = 8
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic signed [AUDIO_WIDTH_P-1:0] ing_left,
  input  logic signed [AUDIO_WIDTH_P-1:0] ing_right,
  input  logic                            ing_valid,
  output logic                            ing_ready,
  output logic                            i2s_bclk,
  output logic                            i2s_lrclk,
  output logic                            i2s_sdata,
  input  logic [DIV_WIDTH_P-1:0]          cr_bclk_div,
  output logic                            sr_underrun
);

  localparam int FRAME_BITS = 2 * SLOT_WIDTH_P;
  localparam int BW         = $clog2(FRAME_BITS);
  localparam int PAD        = SLOT_WIDTH_P - AUDIO_WIDTH_P;

  logic [DIV_WIDTH_P-1:0]   div_cnt;
  logic [DIV_WIDTH_P-1:0]   div_lim;
  logic                     div_hit;
  logic                     fall_ev;
  logic                     load_ev;
  logic                     accept;
  logic [BW-1:0]            bit_cnt;
  logic [BW-1:0]            bit_nxt;
  logic [FRAME_BITS-1:0]    shreg;
  logic [SLOT_WIDTH_P-1:0]  slot_l;
  logic [SLOT_WIDTH_P-1:0]  slot_r;
  logic [AUDIO_WIDTH_P-1:0] hold_left;
  logic [AUDIO_WIDTH_P-1:0] hold_right;
  logic [AUDIO_WIDTH_P-1:0] src_left;
  logic [AUDIO_WIDTH_P-1:0] src_right;
  logic                     hold_full;

  // A divide setting of 0 behaves like 1; >= keeps the compare safe if the
  // setting shrinks below the running count.
  assign div_lim = (cr_bclk_div == '0) ? DIV_WIDTH_P'(1) : cr_bclk_div;
  assign div_hit = (div_cnt >= (div_lim - DIV_WIDTH_P'(1)));
  assign fall_ev = div_hit && i2s_bclk;

  assign bit_nxt = (bit_cnt == BW'(FRAME_BITS - 1)) ? '0 : bit_cnt + 1'b1;
  // Loading at bit 1 gives the one-bit delay behind the lrclk edge at bit 0.
  assign load_ev = fall_ev && (bit_nxt == BW'(1));

  assign ing_ready = !hold_full;
  assign accept    = ing_valid && !hold_full;
  assign i2s_sdata = shreg[FRAME_BITS-1];

`ifdef MIXER_I2S_TX_REPEAT_ON_UNDERRUN_EN
  logic [AUDIO_WIDTH_P-1:0] last_left;
  logic [AUDIO_WIDTH_P-1:0] last_right;

  // Remember the most recently loaded pair so an underrun can replay it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_left  <= '0;
      last_right <= '0;
    end else if (load_ev && hold_full) begin
      last_left  <= hold_left;
      last_right <= hold_right;
    end
  end

  assign src_left  = hold_full ? hold_left  : last_left;
  assign src_right = hold_full ? hold_right : last_right;
`else
  assign src_left  = hold_full ? hold_left  : '0;
  assign src_right = hold_full ? hold_right : '0;
`endif

  // MSB-align each sample in its slot; the low pad bits are zero.
  assign slot_l = SLOT_WIDTH_P'(src_left)  << PAD;
  assign slot_r = SLOT_WIDTH_P'(src_right) << PAD;

  // Divider: toggle bclk every D clk cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt  <= '0;
      i2s_bclk <= 1'b0;
    end else if (div_hit) begin
      div_cnt  <= '0;
      i2s_bclk <= !i2s_bclk;
    end else begin
      div_cnt  <= div_cnt + 1'b1;
    end
  end

  // Bit position within the frame and word select, both advanced on bclk falls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt   <= BW'(FRAME_BITS - 1);
      i2s_lrclk <= 1'b1;
    end else if (fall_ev) begin
      bit_cnt   <= bit_nxt;
      i2s_lrclk <= (bit_nxt >= BW'(SLOT_WIDTH_P));
    end
  end

  // Output shifter: load a whole frame at bit 1, otherwise shift out MSB first.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg <= '0;
    end else if (load_ev) begin
      shreg <= {slot_l, slot_r};
    end else if (fall_ev) begin
      shreg <= {shreg[FRAME_BITS-2:0], 1'b0};
    end
  end

  // Single-entry holding register; an accept in a load cycle feeds the next frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_full  <= 1'b0;
      hold_left  <= '0;
      hold_right <= '0;
    end else if (accept) begin
      hold_full  <= 1'b1;
      hold_left  <= ing_left;
      hold_right <= ing_right;
    end else if (load_ev) begin
      hold_full  <= 1'b0;
    end
  end

  // Underrun flag: one clk, aligned with the bclk fall that loads the frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sr_underrun <= 1'b0;
    else        sr_underrun <= load_ev && !hold_full;
  end

endmodule
